// File: rtl/dmem_responder_if.sv
// rtl/dmem_responder_if.sv - request/response handshake bundle for the data-memory responder
interface dmem_responder_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [2:0]  req_len;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic        resp_ready;
  logic [31:0] resp_rdata;
  logic        resp_err;

  modport master (
    output req_valid, req_we, req_len, req_addr, req_wdata, resp_ready,
    input  req_ready, resp_valid, resp_rdata, resp_err
  );

  modport slave (
    input  req_valid, req_we, req_len, req_addr, req_wdata, resp_ready,
    output req_ready, resp_valid, resp_rdata, resp_err
  );
endinterface

// File: rtl/dmem_responder.sv
// rtl/dmem_responder.sv - single-outstanding load/store responder over a word-organised array
module dmem_responder #(
  parameter int AW_WORDS = 10
) (
  input  logic                    clk,
  input  logic                    rst,
  dmem_responder_if.slave         bus,
  output logic                    busy
);
  typedef enum logic [1:0] {IDLE, READ, WRITE, RESP} state_t;

  state_t state, next_state;

  logic [31:0]         mem [0:(2**AW_WORDS)-1];
  logic [AW_WORDS+1:0] a_addr;
  logic                a_we;
  logic [2:0]          a_len;
  logic [31:0]         a_wdata;
  logic [31:0]         wr_word;
  logic [31:0]         resp_rdata_q;
  logic                resp_err_q;
  logic [31:0]         mem_word;
  logic [31:0]         load_ext;
  logic [31:0]         merged;
  logic                illegal;
  logic                unused_addr_bits;

  assign unused_addr_bits = ^bus.req_addr[31:AW_WORDS+2];
  assign mem_word = mem[a_addr[AW_WORDS+1:2]];

  assign illegal = (bus.req_len == 3'b011) || (bus.req_len == 3'b110) ||
                   (bus.req_len == 3'b111) || (bus.req_we && bus.req_len[2]) ||
                   (bus.req_len[1:0] == 2'b01 && bus.req_addr[0]) ||
                   (bus.req_len[1:0] == 2'b10 && bus.req_addr[1:0] != 2'b00);

  always_comb begin
    logic [7:0]  lane_b;
    logic [15:0] lane_h;
    lane_b   = mem_word[7:0];
    lane_h   = a_addr[1] ? mem_word[31:16] : mem_word[15:0];
    load_ext = mem_word;
    merged   = mem_word;
    case (a_addr[1:0])
      2'd0: lane_b = mem_word[7:0];
      2'd1: lane_b = mem_word[15:8];
      2'd2: lane_b = mem_word[23:16];
      default: lane_b = mem_word[31:24];
    endcase
    case (a_len[1:0])
      2'b00: load_ext = {{24{lane_b[7] & ~a_len[2]}}, lane_b};
      2'b01: load_ext = {{16{lane_h[15] & ~a_len[2]}}, lane_h};
      default: load_ext = mem_word;
    endcase
    // Read-modify-write: only the addressed lane takes store data.
    if (a_len[1:0] == 2'b00) begin
      case (a_addr[1:0])
        2'd0: merged = {mem_word[31:8], a_wdata[7:0]};
        2'd1: merged = {mem_word[31:16], a_wdata[7:0], mem_word[7:0]};
        2'd2: merged = {mem_word[31:24], a_wdata[7:0], mem_word[15:0]};
        default: merged = {a_wdata[7:0], mem_word[23:0]};
      endcase
    end else if (a_addr[1]) begin
      merged = {a_wdata[15:0], mem_word[15:0]};
    end else begin
      merged = {mem_word[31:16], a_wdata[15:0]};
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE: begin
        if (bus.req_valid) begin
          if (illegal)                                   next_state = RESP;
          else if (bus.req_we && bus.req_len[1:0] == 2'b10) next_state = WRITE;
          else                                           next_state = READ;
        end
      end
      READ:  next_state = a_we ? WRITE : RESP;
      WRITE: next_state = RESP;
      RESP:  if (bus.resp_ready) next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      a_addr       <= '0;
      a_we         <= 1'b0;
      a_len        <= 3'b000;
      a_wdata      <= '0;
      wr_word      <= '0;
      resp_rdata_q <= '0;
      resp_err_q   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.req_valid) begin
            a_addr       <= bus.req_addr[AW_WORDS+1:0];
            a_we         <= bus.req_we;
            a_len        <= bus.req_len;
            a_wdata      <= bus.req_wdata;
            wr_word      <= bus.req_wdata;
            resp_rdata_q <= '0;
            resp_err_q   <= illegal;
          end
        end
        READ: begin
          if (a_we) wr_word      <= merged;
          else      resp_rdata_q <= load_ext;
        end
        WRITE: begin
          resp_rdata_q <= '0;
          resp_err_q   <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  // Array is not reset; reset forces IDLE so an aborted RMW never writes.
  always_ff @(posedge clk) begin
    if (state == WRITE) mem[a_addr[AW_WORDS+1:2]] <= wr_word;
  end

  assign bus.req_ready  = (state == IDLE);
  assign bus.resp_valid = (state == RESP);
  assign bus.resp_rdata = resp_rdata_q;
  assign bus.resp_err   = resp_err_q;
  assign busy           = (state != IDLE);
endmodule

// File: tb/tb_dmem_responder.sv
// tb/tb_dmem_responder.sv - directed self-checking bench for dmem_responder
module tb_dmem_responder;
  logic clk = 1'b0;
  logic rst = 1'b0;
  logic busy;
  int   passed = 0;
  int   total  = 0;

  dmem_responder_if bus();

  dmem_responder #(.AW_WORDS(10)) dut (
    .clk  (clk),
    .rst  (rst),
    .bus  (bus),
    .busy (busy)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Issue one request from 1ns after a rising edge; cyc = cycle in which resp_valid was seen.
  task automatic do_req(input logic we, input logic [2:0] len, input logic [31:0] addr,
                        input logic [31:0] wdata, output logic [31:0] rdata,
                        output logic err, output int cyc);
    bus.req_valid = 1'b1;
    bus.req_we    = we;
    bus.req_len   = len;
    bus.req_addr  = addr;
    bus.req_wdata = wdata;
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
    cyc = 1;
    while (!bus.resp_valid && cyc < 20) begin
      @(posedge clk); #1;
      cyc++;
    end
    if (!bus.resp_valid) cyc = 99;
    rdata = bus.resp_rdata;
    err   = bus.resp_err;
    @(posedge clk); #1;
  endtask

  task automatic test_reset;
    repeat (2) @(posedge clk);
    #1;
    total++; if (bus.req_ready !== 1'b1) $display("FAIL reset_req_ready got %b want 1", bus.req_ready); else passed++;
    total++; if (bus.resp_valid !== 1'b0) $display("FAIL reset_resp_valid got %b want 0", bus.resp_valid); else passed++;
    total++; if (busy !== 1'b0) $display("FAIL reset_busy got %b want 0", busy); else passed++;
    total++; if (bus.resp_rdata !== 32'h0) $display("FAIL reset_rdata got %h want 0", bus.resp_rdata); else passed++;
    total++; if (bus.resp_err !== 1'b0) $display("FAIL reset_err got %b want 0", bus.resp_err); else passed++;
    rst = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_word_roundtrip;
    logic [31:0] rd; logic er; int cyc;
    do_req(1'b1, 3'b010, 32'h10, 32'hDEADBEEF, rd, er, cyc);
    total++; if (cyc !== 2) $display("FAIL sw_latency got %0d want 2", cyc); else passed++;
    total++; if (er !== 1'b0 || rd !== 32'h0) $display("FAIL sw_resp got err=%b rdata=%h want err=0 rdata=0", er, rd); else passed++;
    do_req(1'b0, 3'b010, 32'h10, 32'h0, rd, er, cyc);
    total++; if (cyc !== 2) $display("FAIL lw_latency got %0d want 2", cyc); else passed++;
    total++; if (rd !== 32'hDEADBEEF) $display("FAIL lw_data got %h want deadbeef", rd); else passed++;
  endtask

  task automatic test_rmw;
    logic [31:0] rd; logic er; int cyc;
    do_req(1'b1, 3'b000, 32'h13, 32'h000000AA, rd, er, cyc);
    total++; if (cyc !== 3) $display("FAIL sb_latency got %0d want 3", cyc); else passed++;
    do_req(1'b1, 3'b001, 32'h10, 32'h00001234, rd, er, cyc);
    total++; if (cyc !== 3) $display("FAIL sh_latency got %0d want 3", cyc); else passed++;
    do_req(1'b0, 3'b010, 32'h10, 32'h0, rd, er, cyc);
    total++; if (rd !== 32'hAAAD1234) $display("FAIL rmw_data got %h want aaad1234", rd); else passed++;
  endtask

  task automatic test_extension;
    logic [31:0] rd; logic er; int cyc;
    logic [2:0]  lens [5] = '{3'b000, 3'b100, 3'b001, 3'b101, 3'b000};
    logic [31:0] adrs [5] = '{32'h23, 32'h23, 32'h22, 32'h22, 32'h20};
    logic [31:0] exps [5] = '{32'hFFFFFF80, 32'h00000080, 32'hFFFF80FF, 32'h000080FF, 32'h00000001};
    do_req(1'b1, 3'b010, 32'h20, 32'h80FF7F01, rd, er, cyc);
    for (int i = 0; i < 5; i++) begin
      do_req(1'b0, lens[i], adrs[i], 32'h0, rd, er, cyc);
      total++;
      if (rd !== exps[i] || cyc !== 2)
        $display("FAIL ext_%0d got %h cyc %0d want %h cyc 2", i, rd, cyc, exps[i]);
      else passed++;
    end
  endtask

  task automatic test_misalign;
    logic [31:0] rd; logic er; int cyc;
    logic        wes  [3] = '{1'b0, 1'b1, 1'b0};
    logic [2:0]  lens [3] = '{3'b010, 3'b001, 3'b111};
    logic [31:0] adrs [3] = '{32'h22, 32'h11, 32'h20};
    for (int i = 0; i < 3; i++) begin
      do_req(wes[i], lens[i], adrs[i], 32'hFFFFFFFF, rd, er, cyc);
      total++;
      if (er !== 1'b1 || rd !== 32'h0 || cyc !== 1)
        $display("FAIL err_%0d got err=%b rdata=%h cyc=%0d want err=1 rdata=0 cyc=1", i, er, rd, cyc);
      else passed++;
    end
    do_req(1'b0, 3'b010, 32'h20, 32'h0, rd, er, cyc);
    total++; if (rd !== 32'h80FF7F01) $display("FAIL err_nochange20 got %h want 80ff7f01", rd); else passed++;
    do_req(1'b0, 3'b010, 32'h10, 32'h0, rd, er, cyc);
    total++; if (rd !== 32'hAAAD1234) $display("FAIL err_nochange10 got %h want aaad1234", rd); else passed++;
  endtask

  task automatic test_backpressure_wrap;
    logic [31:0] rd; logic er; int cyc;
    bus.resp_ready = 1'b0;
    bus.req_valid  = 1'b1;
    bus.req_we     = 1'b0;
    bus.req_len    = 3'b010;
    bus.req_addr   = 32'h20;
    bus.req_wdata  = 32'h0;
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
    cyc = 1;
    while (!bus.resp_valid && cyc < 20) begin
      @(posedge clk); #1;
      cyc++;
    end
    total++; if (cyc !== 2) $display("FAIL bp_latency got %0d want 2", cyc); else passed++;
    bus.req_we    = 1'b1;
    bus.req_wdata = 32'h0;
    for (int i = 0; i < 5; i++) begin
      bus.req_valid = ~bus.req_valid;
      @(posedge clk); #1;
      total++;
      if (bus.resp_valid !== 1'b1 || bus.resp_rdata !== 32'h80FF7F01 || bus.req_ready !== 1'b0 || busy !== 1'b1)
        $display("FAIL bp_hold_%0d got valid=%b rdata=%h req_ready=%b want valid=1 rdata=80ff7f01 req_ready=0",
                 i, bus.resp_valid, bus.resp_rdata, bus.req_ready);
      else passed++;
    end
    bus.req_valid  = 1'b0;
    bus.resp_ready = 1'b1;
    @(posedge clk); #1;
    total++; if (bus.resp_valid !== 1'b0 || bus.req_ready !== 1'b1) $display("FAIL bp_release got valid=%b req_ready=%b want 0/1", bus.resp_valid, bus.req_ready); else passed++;
    do_req(1'b0, 3'b010, 32'h20, 32'h0, rd, er, cyc);
    total++; if (rd !== 32'h80FF7F01) $display("FAIL bp_ignored_store got %h want 80ff7f01", rd); else passed++;
    do_req(1'b1, 3'b010, 32'h1000, 32'hCAFEF00D, rd, er, cyc);
    do_req(1'b0, 3'b010, 32'h0, 32'h0, rd, er, cyc);
    total++; if (rd !== 32'hCAFEF00D) $display("FAIL wrap got %h want cafef00d", rd); else passed++;
  endtask

  task automatic test_async_reset;
    logic [31:0] rd; logic er; int cyc;
    do_req(1'b1, 3'b010, 32'h30, 32'h11223344, rd, er, cyc);
    bus.req_valid = 1'b1;
    bus.req_we    = 1'b1;
    bus.req_len   = 3'b001;
    bus.req_addr  = 32'h30;
    bus.req_wdata = 32'h00005555;
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
    total++; if (busy !== 1'b1) $display("FAIL ar_in_read got busy=%b want 1", busy); else passed++;
    #2 rst = 1'b0;
    #1;
    total++;
    if (busy !== 1'b0 || bus.req_ready !== 1'b1 || bus.resp_valid !== 1'b0 || bus.resp_rdata !== 32'h0 || bus.resp_err !== 1'b0)
      $display("FAIL ar_immediate got busy=%b req_ready=%b valid=%b rdata=%h err=%b want 0/1/0/0/0",
               busy, bus.req_ready, bus.resp_valid, bus.resp_rdata, bus.resp_err);
    else passed++;
    @(posedge clk); #3;
    rst = 1'b1;
    @(posedge clk); #1;
    do_req(1'b0, 3'b010, 32'h30, 32'h0, rd, er, cyc);
    total++; if (rd !== 32'h11223344) $display("FAIL ar_unchanged got %h want 11223344", rd); else passed++;
  endtask

  initial begin
    bus.req_valid  = 1'b0;
    bus.req_we     = 1'b0;
    bus.req_len    = 3'b000;
    bus.req_addr   = 32'h0;
    bus.req_wdata  = 32'h0;
    bus.resp_ready = 1'b1;
    test_reset();
    test_word_roundtrip();
    test_rmw();
    test_extension();
    test_misalign();
    test_backpressure_wrap();
    test_async_reset();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule

// File: doc/dmem_responder.md
Name: dmem_responder

Overview:
- Data-memory responder on the far side of the MEM stage's load/store requests.
- Accepts one request at a time over a valid/ready handshake and performs byte, half-word or word loads and stores against an internal word-organised array.
- Partial stores are done as read-modify-write. Loads are sign- or zero-extended.
- Returns a response (load data or store completion) over a second valid/ready handshake. The MEM stage stalls on `busy`.

Parameters:
- AW_WORDS, 10, log2 of array depth in 32-bit words (1024 words, 4 KiB).

Ports:
- clk  input  1  clock, rising edge
- rst  input  1  asynchronous, active-low reset
- req_valid  input  1  request present
- req_ready  output  1  responder can accept a request (IDLE only)
- req_we  input  1  1 = store, 0 = load
- req_len  input  3  access length/extension: 000 lb, 001 lh, 010 lw, 100 lbu, 101 lhu; stores use bits[1:0] only (00 sb, 01 sh, 10 sw)
- req_addr  input  32  byte address
- req_wdata  input  32  store data; the low byte or half-word is used for sb/sh
- resp_valid  output  1  response present
- resp_ready  input  1  consumer accepts response
- resp_rdata  output  32  extended load data; 0 for stores and errors
- resp_err  output  1  misaligned or illegal access
- busy  output  1  a transaction is in flight (state != IDLE)

Behaviour:
- **Reset (rst low, asynchronous):**
  - state = IDLE; req_ready = 1; resp_valid = 0; resp_rdata = 0; resp_err = 0; busy = 0.
  - Latched request registers are cleared.
  - Array contents are not reset.
  - Reset mid-transaction aborts it. A partial store that has not reached WRITE leaves the array unchanged.
- **Handshake:**
  - A request is accepted when req_valid & req_ready at a rising edge. addr, we, len and wdata are latched.
  - Request inputs are ignored outside IDLE.
  - A response completes when resp_valid & resp_ready. resp_valid, resp_rdata and resp_err are held stable until then.
- **Indexing:** word index = addr[AW_WORDS+1:2]. Upper address bits are ignored, so addresses wrap modulo 4*2^AW_WORDS.
- **Errors:** an access is illegal if any of these hold:
  - half-word with addr[0] = 1;
  - word with addr[1:0] != 0;
  - req_len in {011, 110, 111};
  - store with req_len[2] = 1.
- **States:** IDLE, READ, WRITE, RESP.
  - IDLE -> RESP on accept of an illegal access. resp_err = 1, no array access.
  - IDLE -> WRITE on accept of sw.
  - IDLE -> READ on accept of a load, sb or sh.
  - READ: synchronous array read, one cycle. A load goes to RESP with extended data registered. sb/sh goes to WRITE.
  - WRITE: the array word is written. For sb/sh, the selected byte/half of the READ data is replaced and the other bytes are preserved. Goes to RESP with rdata = 0, err = 0.
  - RESP: resp_valid = 1. On resp_ready go to IDLE; req_ready rises the next cycle.
- **Latency (accept edge = cycle 0, resp_ready held high):**
  - load: resp_valid in cycle 2;
  - sw: cycle 2;
  - sb/sh: cycle 3;
  - error: cycle 1.
  - Throughput is at most 1 transaction per (latency + 1) cycles.
- **Lane selection:**
  - byte lane = addr[1:0], little-endian (lane 0 = bits[7:0]).
  - half lane = addr[1] (0 = bits[15:0]).
- **Extension:**
  - lb/lh sign-extend from bit 7/15.
  - lbu/lhu zero-extend.
  - lw returns the word unchanged.
- **Ordering:** a load following a store to the same word observes the stored data, because the store has completed its WRITE before IDLE is re-entered.
- **resp_ready low in RESP:** hold indefinitely. No new request is accepted.

Test Plan:
- **Word round-trip.** Reset, then sw addr 0x10 data 0xDEADBEEF, then lw 0x10.
  - Required: store response in cycle 2 with err 0; load returns 0xDEADBEEF in cycle 2.
- **Byte/half RMW.** On word 0x10 = 0xDEADBEEF: sb 0x13 data 0x000000AA, then sh 0x10 data 0x00001234, then lw 0x10.
  - Required: load returns 0xAAAD1234; each partial store response arrives in cycle 3.
- **Extension.** Word 0x20 = 0x80FF7F01.
  - Required: lb 0x23 -> 0xFFFFFF80; lbu 0x23 -> 0x00000080; lh 0x22 -> 0xFFFF80FF; lhu 0x22 -> 0x000080FF; lb 0x20 -> 0x00000001.
- **Misalignment.** lw 0x22, sh 0x11, len 111.
  - Required: each gives resp_err 1 and rdata 0 in cycle 1; a following lw 0x20 shows the array unchanged.
- **Backpressure and wrap.** Hold resp_ready low for 5 cycles during a load.
  - Required: resp_valid and resp_rdata stay stable; req_ready stays 0; toggling req_valid is ignored.
  - Then sw to 0x1000 (AW_WORDS = 10) and lw 0x0 returns that data.
- **Async reset mid-op.** Assert rst in the READ cycle of sh 0x30 (prior word 0x11223344).
  - Required: outputs go to reset values immediately, without waiting for a clock edge; after release, lw 0x30 returns 0x11223344.
